// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared owner encodings and park address for the NES bus arbiters
package nes_bus_pkg;

  typedef enum logic [1:0] {
    OWN_CPU      = 2'd0,
    OWN_HCI      = 2'd1,
    OWN_DMA      = 2'd2,
    OWN_HANDOVER = 2'd3
  } owner_e;

  // Unmapped on cpumc and outside $2000-$3FFF, so parked reads cannot disturb the PPU.
  localparam logic [15:0] PARK_ADDR_DEFAULT = 16'h5000;

endpackage

// File: rtl/cpumc_arbiter.sv
// rtl/cpumc_arbiter.sv - CPU memory bus arbiter: CPU / HCI / DMA owners with parked handover cycles
module cpumc_arbiter
  import nes_bus_pkg::*;
#(
  parameter int          DMA_MAX_BURST = 256,
  parameter int          CPU_SLOT      = 4,
  parameter logic [15:0] PARK_ADDR     = PARK_ADDR_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  output logic [7:0]  cpu_d_out,
  input  logic        hci_req_in,
  input  logic [15:0] hci_a_in,
  input  logic        hci_r_nw_in,
  input  logic [7:0]  hci_d_in,
  output logic        hci_gnt_out,
  output logic [7:0]  hci_d_out,
  output logic        hci_dvalid_out,
  input  logic        dma_req_in,
  input  logic [15:0] dma_a_in,
  input  logic        dma_r_nw_in,
  input  logic [7:0]  dma_d_in,
  output logic        dma_gnt_out,
  output logic [7:0]  dma_d_out,
  output logic        dma_dvalid_out,
  output logic [15:0] mc_a_out,
  output logic        mc_r_nw_out,
  output logic [7:0]  mc_d_out,
  input  logic [7:0]  mc_d_in,
  output logic [1:0]  owner_out
);

  localparam int BW = $clog2(DMA_MAX_BURST + 1);
  localparam int YW = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;

  owner_e          r_state;
  owner_e          r_target;
  logic [BW-1:0]   r_burst;
  logic [YW-1:0]   r_yield;
  logic            r_ret_vld;
  owner_e          r_ret_owner;

  logic [YW-1:0]   w_yield_dec;
  logic [BW-1:0]   w_burst_inc;
  logic            w_burst_hit;
  logic            w_dma_leave;

  // The yield counter is charged for the current CPU cycle before DMA eligibility is judged.
  assign w_yield_dec = (r_yield != '0) ? r_yield - YW'(1) : r_yield;
  assign w_burst_inc = (r_burst == BW'(DMA_MAX_BURST)) ? r_burst : r_burst + BW'(1);
  assign w_burst_hit = (w_burst_inc == BW'(DMA_MAX_BURST));
  assign w_dma_leave = hci_req_in || !dma_req_in || w_burst_hit;

  always_comb begin
    mc_a_out    = PARK_ADDR;
    mc_r_nw_out = 1'b1;
    mc_d_out    = 8'h00;
    case (r_state)
      OWN_CPU: begin
        mc_a_out    = cpu_a_in;
        mc_r_nw_out = cpu_r_nw_in;
        mc_d_out    = cpu_d_in;
      end
      OWN_HCI: begin
        mc_a_out    = hci_a_in;
        mc_r_nw_out = hci_r_nw_in;
        mc_d_out    = hci_d_in;
      end
      OWN_DMA: begin
        mc_a_out    = dma_a_in;
        mc_r_nw_out = dma_r_nw_in;
        mc_d_out    = dma_d_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= OWN_CPU;
      r_target    <= OWN_CPU;
      r_burst     <= '0;
      r_yield     <= '0;
      r_ret_vld   <= 1'b0;
      r_ret_owner <= OWN_CPU;
    end else begin
      r_ret_vld   <= (r_state != OWN_HANDOVER) && mc_r_nw_out;
      r_ret_owner <= r_state;
      case (r_state)
        OWN_CPU: begin
          r_yield <= w_yield_dec;
          if (hci_req_in) begin
            r_state  <= OWN_HANDOVER;
            r_target <= OWN_HCI;
          end else if (dma_req_in && w_yield_dec == '0) begin
            r_state  <= OWN_HANDOVER;
            r_target <= OWN_DMA;
          end
        end
        OWN_HCI: begin
          if (!hci_req_in) begin
            r_state  <= OWN_HANDOVER;
            r_target <= (dma_req_in && r_yield == '0) ? OWN_DMA : OWN_CPU;
          end
        end
        OWN_DMA: begin
          r_burst <= w_dma_leave ? '0 : w_burst_inc;
          if (w_dma_leave) begin
            r_state  <= OWN_HANDOVER;
            r_target <= hci_req_in ? OWN_HCI : OWN_CPU;
          end
          if (!hci_req_in && dma_req_in && w_burst_hit) r_yield <= YW'(CPU_SLOT);
        end
        default: r_state <= r_target;
      endcase
    end
  end

  assign owner_out      = r_state;
  assign cpu_rdy_out    = (r_state == OWN_CPU);
  assign hci_gnt_out    = (r_state == OWN_HCI);
  assign dma_gnt_out    = (r_state == OWN_DMA);

  assign cpu_d_out      = (r_ret_vld && r_ret_owner == OWN_CPU) ? mc_d_in : 8'h00;
  assign hci_dvalid_out = r_ret_vld && (r_ret_owner == OWN_HCI);
  assign hci_d_out      = hci_dvalid_out ? mc_d_in : 8'h00;
  assign dma_dvalid_out = r_ret_vld && (r_ret_owner == OWN_DMA);
  assign dma_d_out      = dma_dvalid_out ? mc_d_in : 8'h00;

endmodule

// File: tb/tb_cpumc_arbiter.sv
// tb/tb_cpumc_arbiter.sv - randomized and directed bench for cpumc_arbiter with a cycle model
module tb_cpumc_arbiter;

  localparam int MAXB = 256;
  localparam int SLOT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a, hci_a, dma_a;
  logic        cpu_rnw, hci_rnw, dma_rnw;
  logic [7:0]  cpu_d, hci_d, dma_d;
  logic        hci_req, dma_req;
  logic [7:0]  mc_din;
  logic        cpu_rdy, hci_gnt, dma_gnt, hci_dvalid, dma_dvalid;
  logic [7:0]  cpu_dout, hci_dout, dma_dout, mc_dout;
  logic [15:0] mc_a;
  logic        mc_rnw;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;

  // Reference state: who owns the bus, where a handover is heading, DMA run length, CPU cycles owed.
  int   m_own = 0, m_tgt = 0, m_run = 0, m_owe = 0, m_ret_own = 0;
  bit   m_ret_vld = 0;
  int   tr[600];

  cpumc_arbiter #(.DMA_MAX_BURST(MAXB), .CPU_SLOT(SLOT), .PARK_ADDR(16'h5000)) dut (
    .clk_in(clk), .rst_in(rst),
    .cpu_a_in(cpu_a), .cpu_r_nw_in(cpu_rnw), .cpu_d_in(cpu_d),
    .cpu_rdy_out(cpu_rdy), .cpu_d_out(cpu_dout),
    .hci_req_in(hci_req), .hci_a_in(hci_a), .hci_r_nw_in(hci_rnw), .hci_d_in(hci_d),
    .hci_gnt_out(hci_gnt), .hci_d_out(hci_dout), .hci_dvalid_out(hci_dvalid),
    .dma_req_in(dma_req), .dma_a_in(dma_a), .dma_r_nw_in(dma_rnw), .dma_d_in(dma_d),
    .dma_gnt_out(dma_gnt), .dma_d_out(dma_dout), .dma_dvalid_out(dma_dvalid),
    .mc_a_out(mc_a), .mc_r_nw_out(mc_rnw), .mc_d_out(mc_dout), .mc_d_in(mc_din),
    .owner_out(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] exp_bus();
    case (m_own)
      0:       return {cpu_a, cpu_rnw, cpu_d};
      1:       return {hci_a, hci_rnw, hci_d};
      2:       return {dma_a, dma_rnw, dma_d};
      default: return {16'h5000, 1'b1, 8'h00};
    endcase
  endfunction

  initial begin : model
    logic [24:0] bus;
    int left;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_own = 0; m_tgt = 0; m_run = 0; m_owe = 0; m_ret_vld = 0; m_ret_own = 0;
      end else begin
        bus = exp_bus();
        m_ret_vld = (m_own != 3) && bus[8];
        m_ret_own = m_own;
        case (m_own)
          0: begin
            left = (m_owe > 0) ? m_owe - 1 : 0;
            m_owe = left;
            if (hci_req) begin m_tgt = 1; m_own = 3; end
            else if (dma_req && left == 0) begin m_tgt = 2; m_own = 3; end
          end
          1: if (!hci_req) begin m_tgt = (dma_req && m_owe == 0) ? 2 : 0; m_own = 3; end
          2: begin
            m_run++;
            if (hci_req) begin m_tgt = 1; m_own = 3; end
            else if (!dma_req) begin m_tgt = 0; m_own = 3; end
            else if (m_run >= MAXB) begin m_tgt = 0; m_own = 3; m_owe = SLOT; end
          end
          default: begin m_own = m_tgt; m_run = 0; end
        endcase
      end
    end
  end

  initial begin : compare
    logic cv, hv, dv;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cv = m_ret_vld && m_ret_own == 0;
        hv = m_ret_vld && m_ret_own == 1;
        dv = m_ret_vld && m_ret_own == 2;
        chk("bus", {mc_a, mc_rnw, mc_dout}, exp_bus());
        chk("owner", {owner, cpu_rdy, hci_gnt, dma_gnt},
            {2'(m_own), m_own == 0, m_own == 1, m_own == 2});
        chk("ret", {cpu_dout, hci_dout, hci_dvalid, dma_dout, dma_dvalid},
            {cv ? mc_din : 8'h00, hv ? mc_din : 8'h00, hv, dv ? mc_din : 8'h00, dv});
      end
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
    mc_din = 8'($urandom);
    cpu_a = 16'($urandom); cpu_rnw = 1'($urandom); cpu_d = 8'($urandom);
    hci_a = 16'($urandom); hci_rnw = 1'($urandom); hci_d = 8'($urandom);
    dma_a = 16'($urandom); dma_rnw = 1'($urandom); dma_d = 8'($urandom);
  endtask

  task automatic obs();
    #3;
  endtask

  task automatic wait_dma(input string name);
    int k;
    k = 0;
    nc(); obs();
    while (!dma_gnt && k < 30) begin
      nc(); obs(); k++;
    end
    if (!dma_gnt) chk(name, 0, 1);
  endtask

  initial begin
    int i0, r, c, j;
    rst = 1'b1; hci_req = 0; dma_req = 0; mc_din = 0;
    cpu_a = 0; cpu_rnw = 1; cpu_d = 0; hci_a = 0; hci_rnw = 1; hci_d = 0;
    dma_a = 0; dma_rnw = 1; dma_d = 0;
    repeat (3) @(posedge clk);
    #4;
    chk("reset_owner", owner, 2'd0);
    chk("reset_ctl", {cpu_rdy, hci_gnt, dma_gnt, hci_dvalid, dma_dvalid}, 5'b10000);
    chk("reset_data", {cpu_dout, hci_dout, dma_dout}, 24'h0);
    @(posedge clk); #1; rst = 1'b0;

    repeat (100) nc();
    nc(); cpu_a = 16'h0005; cpu_rnw = 1'b1;
    nc(); mc_din = 8'h3C; obs();
    chk("idle_read", {owner, cpu_dout, hci_dvalid, dma_dvalid}, {2'd0, 8'h3C, 2'b00});

    nc(); hci_req = 1; hci_a = 16'h8000; hci_rnw = 1;
    nc(); hci_a = 16'h8000; hci_rnw = 1; obs();
    chk("hci_park", {owner, mc_a, cpu_rdy}, {2'd3, 16'h5000, 1'b0});
    nc(); hci_a = 16'h8000; hci_rnw = 1; obs();
    chk("hci_grant", {hci_gnt, mc_a, cpu_rdy}, {1'b1, 16'h8000, 1'b0});
    nc(); mc_din = 8'hA5; obs();
    chk("hci_rdata", {hci_dvalid, hci_dout, cpu_rdy}, {1'b1, 8'hA5, 1'b0});
    nc(); hci_req = 0;
    repeat (3) nc();

    dma_req = 1;
    for (int i = 0; i < 600; i++) begin
      nc(); obs(); tr[i] = int'(owner);
    end
    i0 = -1;
    for (int i = 0; i < 40; i++) if (i0 < 0 && tr[i] == 2) i0 = i;
    chk("burst_start", i0 >= 0, 1);
    if (i0 >= 0) begin
      r = 0;
      while (i0 + r < 599 && tr[i0 + r] == 2) r++;
      chk("burst_len", r, 256);
      j = i0 + r;
      chk("burst_park", tr[j], 3);
      c = 0;
      while (j + 1 + c < 590 && tr[j + 1 + c] == 0) c++;
      chk("cpu_slot", c, 4);
      chk("slot_park", tr[j + 1 + c], 3);
      chk("redma", tr[j + 2 + c], 2);
    end

    dma_req = 0;
    repeat (10) nc();
    dma_req = 1;
    wait_dma("pre_wait");
    repeat (8) nc();
    nc(); dma_a = 16'h1234; dma_rnw = 1; hci_req = 1; obs();
    chk("pre_c10", {dma_gnt, mc_a}, {1'b1, 16'h1234});
    nc(); mc_din = 8'h5A; obs();
    chk("pre_return", {owner, dma_dvalid, dma_dout}, {2'd3, 1'b1, 8'h5A});
    nc(); obs();
    chk("pre_hci", owner, 2'd1);
    repeat (3) nc();
    hci_req = 0; dma_req = 0;
    repeat (6) nc();

    nc(); hci_req = 1; dma_req = 1; obs();
    nc(); obs(); chk("sim_park", owner, 2'd3);
    nc(); obs(); chk("sim_hci", {owner, dma_gnt}, {2'd1, 1'b0});
    repeat (3) nc();
    nc(); hci_req = 0; obs();
    nc(); obs(); chk("sim_park2", owner, 2'd3);
    nc(); obs(); chk("sim_dma", {owner, dma_gnt}, {2'd2, 1'b1});

    for (int i = 0; i < 3000; i++) begin
      nc();
      if ($urandom_range(0, 15) == 0) hci_req = ~hci_req;
      if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
    end

    hci_req = 0; dma_req = 1;
    wait_dma("rst_wait");
    nc(); dma_rnw = 1;
    #2; rst = 1'b1;
    #1;
    chk("arst_ctl", {owner, cpu_rdy, hci_gnt, dma_gnt, hci_dvalid, dma_dvalid}, {2'd0, 5'b10000});
    chk("arst_data", {cpu_dout, hci_dout, dma_dout}, 24'h0);
    @(posedge clk); #1; rst = 1'b0; dma_req = 0;
    nc(); obs();
    chk("post_rst", {hci_dvalid, dma_dvalid, owner}, 4'b0000);
    repeat (20) nc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
